sig_mon: RTL

- Receive-side monitor for the 8-bit quadrature signal produced by the DDS signal generator.
- Consumes a sine/cosine sample stream, detects positive-going zero crossings of the sine with hysteresis, and measures period in samples plus per-period peak/trough.
- Checks quadrature phase at each crossing and asserts lock once the period is stable.
- Used on-chip as a self-check and for ILA/register readback.

---
 rtl/sig_mon.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sig_mon.sv
// Receive-side monitor for a DDS quadrature sine/cosine stream.
// Measures the period between rising zero crossings of the sine and the peak/trough within it.
// It also checks cosine quadrature at each crossing and flags lock once the period is stable.
//
// Latency: the measurement is registered and reported one cycle after the crossing sample.
// Backpressure: none. Every cycle with in_valid=1 is consumed, and in_valid=0 freezes all state.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid            sample strobe
//   sin_in, cos_in      signed 8-bit quadrature samples
//   clr                 synchronous clear of the sticky quad_err / ovf flags
//   meas_valid          one-cycle pulse when period/peak/trough update
//   period              samples between the last two crossings
//   peak, trough        signed sine max/min over that period
//   locked              period stable for LOCK_N consecutive reports
//   quad_err, ovf       sticky cosine-phase error / period counter saturation
module sig_mon #(
  parameter int PER_W    = 20,
  parameter int HYST     = 8,
  parameter int QUAD_MIN = 64,
  parameter int PER_TOL  = 2,
  parameter int LOCK_N   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       sin_in,
  input  logic [7:0]       cos_in,
  input  logic             clr,
  output logic             meas_valid,
  output logic [PER_W-1:0] period,
  output logic [7:0]       peak,
  output logic [7:0]       trough,
  output logic             locked,
  output logic             quad_err,
  output logic             ovf
);

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] TRACK  = 1'b1;

  localparam int SW = $clog2(LOCK_N + 1);

  // Largest count still treated as a valid period. Reaching it means no crossing arrived in time.
  localparam logic [PER_W-1:0]        CNT_SAT  = {{(PER_W-1){1'b1}}, 1'b0};
  localparam logic signed [7:0]       ARM_LVL  = 8'(-HYST);
  localparam logic signed [7:0]       QUAD_LVL = 8'(QUAD_MIN);
  localparam logic signed [PER_W:0]   TOL_HI   = (PER_W+1)'(PER_TOL);
  localparam logic signed [PER_W:0]   TOL_LO   = (PER_W+1)'(-PER_TOL);
  localparam logic [SW-1:0]           LOCK_V   = SW'(LOCK_N);

  logic [0:0]             state;
  logic                   armed;
  logic [PER_W-1:0]       cnt;
  logic [PER_W-1:0]       prev_per;
  logic [SW-1:0]          stable;
  logic signed [7:0]      run_max;
  logic signed [7:0]      run_min;

  logic signed [7:0]      sin_s;
  logic signed [7:0]      cos_s;
  logic                   crossing;
  logic                   sat_hit;
  logic                   quad_set;
  logic                   in_tol;
  logic [PER_W-1:0]       cnt_inc;
  logic signed [PER_W:0]  per_diff;
  logic [SW-1:0]          stable_nxt;

  assign sin_s = sin_in;
  assign cos_s = cos_in;

  // Hysteresis: a crossing only counts after the sine has gone clearly negative.
  assign crossing = in_valid && armed && (sin_s >= 8'sd0);
  assign cnt_inc  = cnt + 1'b1;

  // cnt_inc is the period that ends at this crossing sample.
  // The difference uses an extra sign bit so unsigned periods never wrap.
  assign per_diff   = $signed({1'b0, cnt_inc}) - $signed({1'b0, prev_per});
  assign in_tol     = (per_diff <= TOL_HI) && (per_diff >= TOL_LO);
  assign stable_nxt = !in_tol ? '0 :
                      (stable >= LOCK_V) ? LOCK_V : stable + 1'b1;

  assign sat_hit  = in_valid && !crossing && (cnt_inc == CNT_SAT);
  assign quad_set = crossing && (state == TRACK) && (cos_s < QUAD_LVL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      armed      <= 1'b0;
      cnt        <= '0;
      prev_per   <= '0;
      stable     <= '0;
      run_max    <= 8'sh80;
      run_min    <= 8'sh7f;
      meas_valid <= 1'b0;
      period     <= '0;
      peak       <= '0;
      trough     <= '0;
      locked     <= 1'b0;
      quad_err   <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      meas_valid <= 1'b0;
      // Sticky flags: a set in the same cycle as clr takes priority.
      quad_err   <= quad_set || (quad_err && !clr);
      ovf        <= sat_hit  || (ovf && !clr);

      if (in_valid) begin
        if (crossing) begin
          armed <= 1'b0;
        end else if (sin_s < ARM_LVL) begin
          armed <= 1'b1;
        end

        if (crossing) begin
          if (state == TRACK) begin
            meas_valid <= 1'b1;
            period     <= cnt_inc;
            // run_max/run_min do not yet include the crossing sample,
            // which belongs to the next period.
            peak       <= run_max;
            trough     <= run_min;
            stable     <= stable_nxt;
            locked     <= (stable_nxt >= LOCK_V);
            prev_per   <= cnt_inc;
          end
          state   <= TRACK;
          cnt     <= '0;
          run_max <= sin_s;
          run_min <= sin_s;
        end else if (sat_hit) begin
          // Signal lost: drop lock and re-acquire from scratch.
          state   <= SEARCH;
          cnt     <= '0;
          stable  <= '0;
          locked  <= 1'b0;
          run_max <= sin_s;
          run_min <= sin_s;
        end else begin
          cnt <= cnt_inc;
          if (sin_s > run_max) run_max <= sin_s;
          if (sin_s < run_min) run_min <= sin_s;
        end
      end
    end
  end

endmodule
